alu_control_mdu: RTL and testbench
==================================

Name: alu_control_mdu

Overview:
Parametrised successor to the single-cycle ALU control decoder. It decodes {ALUOp, ALUFunction} into a 4-bit ALU operation code, as the current decoder does, and adds the MIPS multiply/divide unit: MULTU, DIVU, MFHI and MFLO. These run on an internal iterative sequencer that holds HI/LO and stalls the pipeline while busy. It sits between the main control unit / ID-EX stage and the ALU and register-file write mux.

Parameters:
DATA_WIDTH, 32, operand and HI/LO width; must be even and at least 4.
ALUOP_WIDTH, 3, width of the ALUOp field from the main control unit.
MDU_CYCLES, DATA_WIDTH, iteration count; fixed at DATA_WIDTH (1 bit per cycle).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
valid_i  in  1  instruction in EX is valid.
ALUOp  in  ALUOP_WIDTH  operation class from the main control unit.
ALUFunction  in  6  instruction funct field.
a_i  in  DATA_WIDTH  rs operand.
b_i  in  DATA_WIDTH  rt operand.
ALUOperation  out  4  ALU operation code (combinational).
stall_o  out  1  freeze PC and IF/ID/ID-EX this cycle.
mdu_busy_o  out  1  sequencer not IDLE.
hilo_rd_o  out  1  current instruction is MFHI or MFLO and is not stalled.
hilo_data_o  out  DATA_WIDTH  HI for MFHI, LO for MFLO, else 0.
hi_o, lo_o  out  DATA_WIDTH each  architectural HI/LO registers.

Behaviour:
- Decode is combinational, keyed on {ALUOp, ALUFunction}; ALUFunction is don't-care when ALUOp is not 111.
- ALUOp 111 (R-type):
  - AND 100100 -> 0000
  - OR 100101 -> 0001
  - NOR 100111 -> 0010
  - ADD 100000 -> 0011
  - SUB 100010 -> 0100
  - SLL 000000 -> 0101
  - SRL 000010 -> 0110
  - MULTU 011001 -> 1010
  - DIVU 011011 -> 1011
  - MFHI 010000 -> 1100
  - MFLO 010010 -> 1101
- ALUOp 100 ADDI -> 0011; 101 ORI -> 0001; 110 ANDI -> 0000; 001 BEQ/BNE -> 0100; 010 LW -> 0111; 011 SW -> 1000.
- Anything else -> 1001 (invalid). Invalid codes do not touch the sequencer.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: valid_i with MULTU -> MUL; with DIVU -> DIV. On the accept edge, latch a_i and b_i, clear the iteration counter, and clear the partial accumulator.
  - MUL: shift-add, one multiplier bit per cycle.
  - DIV: restoring division, one quotient bit per cycle.
  - Counter 0..MDU_CYCLES-1. On the edge where counter == MDU_CYCLES-1, go to DONE.
  - DONE (1 cycle): write HI/LO, then go to IDLE.
- Results:
  - MULTU: {HI, LO} = a*b, 2*DATA_WIDTH bits, unsigned.
  - DIVU: LO = a/b, HI = a%b.
  - Divide by zero: LO = all-ones, HI = a (decided behaviour, not MIPS-undefined).
- Latency: HI/LO hold the new values from the cycle after DONE. mdu_busy_o is high for exactly MDU_CYCLES+1 cycles after the accept edge.
- stall_o = valid_i AND mdu_busy_o AND (decoded op is MULTU, DIVU, MFHI or MFLO). Other instructions flow under a busy MDU. The accept cycle itself does not stall.
- A MULTU/DIVU arriving while busy is held by stall_o. It is accepted in the first cycle the FSM is IDLE.
- MFHI/MFLO: hilo_rd_o = 1 and hilo_data_o = HI/LO only when not stalled. If issued in the cycle after DONE, they return the new value.
- Reset (asynchronous, mid-operation included):
  - State = IDLE; counter, operands, accumulator, HI and LO = 0.
  - stall_o, mdu_busy_o, hilo_rd_o = 0; hilo_data_o = 0.
  - ALUOperation follows inputs combinationally.
- valid_i = 0: no sequencer start; stall_o = 0; ALUOperation still decodes.

Decomposition:
- Shared package alu_pkg:
  - ALUOp class localparams: R 111, ADDI 100, ORI 101, ANDI 110, BR 001, LW 010, SW 011.
  - funct localparams.
  - 4-bit ALUOperation codes.
  - MDU FSM state encoding.
- One sub-module: mdu_iter. It holds operands, accumulator, counter and FSM, with start/op/busy/done/hi/lo ports. The top holds the decode, stall logic and HI/LO read mux.

Test Plan:
- Reset low mid-run, then all 17 decode pairs (plus an invalid pair, e.g. 111_111111) -> reset: all outputs 0, FSM IDLE; decode: each listed code, and 1001 for the invalid pair.
- MULTU a=FFFFFFFF, b=00000002 -> stall_o=0 on accept; mdu_busy_o high for 33 cycles; then HI=00000001, LO=FFFFFFFE.
- DIVU a=100, b=7 -> LO=14, HI=2. DIVU a=5, b=0 -> LO=FFFFFFFF, HI=5.
- MFLO issued 3 cycles after a MULTU accept -> stall_o=1 until busy drops; then hilo_rd_o=1, hilo_data_o = new LO. An ADD issued while busy -> stall_o=0, ALUOperation=0011.
- Reset asserted at iteration 10 of a DIVU -> immediate IDLE, HI=LO=0. A MULTU 3*4 after release -> LO=12, HI=0.
- Back-to-back MULTU then DIVU -> DIVU stalled until IDLE, then accepted. Final HI/LO reflect the DIVU only.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control decoder and the iterative multiply/divide unit.
package alu_pkg;

  localparam logic [2:0] AOP_R    = 3'b111;
  localparam logic [2:0] AOP_ADDI = 3'b100;
  localparam logic [2:0] AOP_ORI  = 3'b101;
  localparam logic [2:0] AOP_ANDI = 3'b110;
  localparam logic [2:0] AOP_BR   = 3'b001;
  localparam logic [2:0] AOP_LW   = 3'b010;
  localparam logic [2:0] AOP_SW   = 3'b011;

  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIVU  = 6'b011011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  localparam logic [3:0] OPC_AND   = 4'b0000;
  localparam logic [3:0] OPC_OR    = 4'b0001;
  localparam logic [3:0] OPC_NOR   = 4'b0010;
  localparam logic [3:0] OPC_ADD   = 4'b0011;
  localparam logic [3:0] OPC_SUB   = 4'b0100;
  localparam logic [3:0] OPC_SLL   = 4'b0101;
  localparam logic [3:0] OPC_SRL   = 4'b0110;
  localparam logic [3:0] OPC_LW    = 4'b0111;
  localparam logic [3:0] OPC_SW    = 4'b1000;
  localparam logic [3:0] OPC_INV   = 4'b1001;
  localparam logic [3:0] OPC_MULTU = 4'b1010;
  localparam logic [3:0] OPC_DIVU  = 4'b1011;
  localparam logic [3:0] OPC_MFHI  = 4'b1100;
  localparam logic [3:0] OPC_MFLO  = 4'b1101;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'b00,
    MDU_MUL  = 2'b01,
    MDU_DIV  = 2'b10,
    MDU_DONE = 2'b11
  } mdu_state_t;

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply/divide sequencer, one operand bit per cycle, owning HI/LO.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MDU_CYCLES = DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_div,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_hi,
  output logic [DATA_WIDTH-1:0] o_lo
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(MDU_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_CYCLES - 1);

  mdu_state_t       r_state;
  logic             r_div;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [2*W-1:0]   r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_hi;
  logic [W-1:0]     r_lo;

  logic [W:0]   w_mul_sum;
  logic [W:0]   w_div_shift;
  logic         w_div_ge;
  logic [W-1:0] w_div_rem;

  // MUL: add multiplicand into the upper half, then shift the whole product right.
  // DIV: r_a shifts the dividend out and the quotient in; r_acc[W-1:0] is the remainder.
  // With a zero divisor every trial succeeds, leaving quotient all-ones and remainder = a.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*W-1:W]} + (r_b[0] ? {1'b0, r_a} : (W+1)'(0));
    w_div_shift = {r_acc[W-1:0], r_a[W-1]};
    w_div_ge    = (w_div_shift >= {1'b0, r_b});
    w_div_rem   = w_div_ge ? W'(w_div_shift - {1'b0, r_b}) : w_div_shift[W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= MDU_IDLE;
      r_div   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        MDU_IDLE: begin
          if (i_start) begin
            r_state <= i_div ? MDU_DIV : MDU_MUL;
            r_div   <= i_div;
            r_a     <= i_a;
            r_b     <= i_b;
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        MDU_MUL: begin
          r_acc <= {w_mul_sum, r_acc[W-1:1]};
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) r_state <= MDU_DONE;
        end
        MDU_DIV: begin
          r_acc[W-1:0] <= w_div_rem;
          r_a          <= {r_a[W-2:0], w_div_ge};
          r_cnt        <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) r_state <= MDU_DONE;
        end
        MDU_DONE: begin
          if (r_div) begin
            r_hi <= r_acc[W-1:0];
            r_lo <= r_a;
          end else begin
            r_hi <= r_acc[2*W-1:W];
            r_lo <= r_acc[W-1:0];
          end
          r_state <= MDU_IDLE;
        end
        default: r_state <= MDU_IDLE;
      endcase
    end
  end

  assign o_busy = (r_state != MDU_IDLE);
  assign o_done = (r_state == MDU_DONE);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: rtl/alu_control_mdu.sv
// ALU control decoder with an attached multicycle MULTU/DIVU unit, stall logic and HI/LO read mux.
module alu_control_mdu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ALUOP_WIDTH = 3,
  parameter int MDU_CYCLES  = DATA_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_i,
  input  logic [ALUOP_WIDTH-1:0] ALUOp,
  input  logic [5:0]             ALUFunction,
  input  logic [DATA_WIDTH-1:0]  a_i,
  input  logic [DATA_WIDTH-1:0]  b_i,
  output logic [3:0]             ALUOperation,
  output logic                   stall_o,
  output logic                   mdu_busy_o,
  output logic                   hilo_rd_o,
  output logic [DATA_WIDTH-1:0]  hilo_data_o,
  output logic [DATA_WIDTH-1:0]  hi_o,
  output logic [DATA_WIDTH-1:0]  lo_o
);
  logic w_multu, w_divu, w_mfhi, w_mflo;
  logic w_busy, w_done, w_start, w_stall;

  always_comb begin
    ALUOperation = OPC_INV;
    case (ALUOp)
      ALUOP_WIDTH'(AOP_R): begin
        case (ALUFunction)
          FN_AND:   ALUOperation = OPC_AND;
          FN_OR:    ALUOperation = OPC_OR;
          FN_NOR:   ALUOperation = OPC_NOR;
          FN_ADD:   ALUOperation = OPC_ADD;
          FN_SUB:   ALUOperation = OPC_SUB;
          FN_SLL:   ALUOperation = OPC_SLL;
          FN_SRL:   ALUOperation = OPC_SRL;
          FN_MULTU: ALUOperation = OPC_MULTU;
          FN_DIVU:  ALUOperation = OPC_DIVU;
          FN_MFHI:  ALUOperation = OPC_MFHI;
          FN_MFLO:  ALUOperation = OPC_MFLO;
          default:  ALUOperation = OPC_INV;
        endcase
      end
      ALUOP_WIDTH'(AOP_ADDI): ALUOperation = OPC_ADD;
      ALUOP_WIDTH'(AOP_ORI):  ALUOperation = OPC_OR;
      ALUOP_WIDTH'(AOP_ANDI): ALUOperation = OPC_AND;
      ALUOP_WIDTH'(AOP_BR):   ALUOperation = OPC_SUB;
      ALUOP_WIDTH'(AOP_LW):   ALUOperation = OPC_LW;
      ALUOP_WIDTH'(AOP_SW):   ALUOperation = OPC_SW;
      default:                ALUOperation = OPC_INV;
    endcase
  end

  assign w_multu = (ALUOperation == OPC_MULTU);
  assign w_divu  = (ALUOperation == OPC_DIVU);
  assign w_mfhi  = (ALUOperation == OPC_MFHI);
  assign w_mflo  = (ALUOperation == OPC_MFLO);

  // Only instructions that touch HI/LO wait on the sequencer; everything else flows past it.
  assign w_stall = valid_i & w_busy & (w_multu | w_divu | w_mfhi | w_mflo);
  assign w_start = valid_i & ~w_busy & (w_multu | w_divu);

  mdu_iter #(
    .DATA_WIDTH (DATA_WIDTH),
    .MDU_CYCLES (MDU_CYCLES)
  ) u_mdu (
    .clk     (clk),
    .rst_n   (reset),
    .i_start (w_start),
    .i_div   (w_divu),
    .i_a     (a_i),
    .i_b     (b_i),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_hi    (hi_o),
    .o_lo    (lo_o)
  );

  assign stall_o     = w_stall;
  assign mdu_busy_o  = w_busy | w_done;
  assign hilo_rd_o   = reset & valid_i & (w_mfhi | w_mflo) & ~w_stall;
  assign hilo_data_o = !hilo_rd_o ? '0 : (w_mfhi ? hi_o : lo_o);

endmodule

// File: tb/tb_alu_control_mdu.sv
// Directed bench for alu_control_mdu: decode table, MULTU/DIVU results via a scoreboard, stalls and reset.
module tb_alu_control_mdu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic [2:0]  ALUOp;
  logic [5:0]  ALUFunction;
  logic [31:0] a_i, b_i;
  logic [3:0]  ALUOperation;
  logic        stall_o, mdu_busy_o, hilo_rd_o;
  logic [31:0] hilo_data_o, hi_o, lo_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_control_mdu dut (
    .clk          (clk),
    .reset        (reset),
    .valid_i      (valid_i),
    .ALUOp        (ALUOp),
    .ALUFunction  (ALUFunction),
    .a_i          (a_i),
    .b_i          (b_i),
    .ALUOperation (ALUOperation),
    .stall_o      (stall_o),
    .mdu_busy_o   (mdu_busy_o),
    .hilo_rd_o    (hilo_rd_o),
    .hilo_data_o  (hilo_data_o),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  logic [2:0] dop [19] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111,
                           3'b111, 3'b111, 3'b111, 3'b100, 3'b101, 3'b110, 3'b001, 3'b010,
                           3'b011, 3'b111, 3'b000};
  logic [5:0] dfn [19] = '{6'b100100, 6'b100101, 6'b100111, 6'b100000, 6'b100010, 6'b000000,
                           6'b000010, 6'b011001, 6'b011011, 6'b010000, 6'b010010, 6'b0,
                           6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b111111, 6'b0};
  logic [3:0] dexp [19] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB, 4'hC, 4'hD,
                            4'h3, 4'h1, 4'h0, 4'h4, 4'h7, 4'h8, 4'h9, 4'h9};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic v, input logic [2:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    valid_i = v; ALUOp = op; ALUFunction = fn; a_i = a; b_i = b;
    #1;
  endtask

  task automatic push_exp(input string tag, input logic is_div, input logic [31:0] a,
                          input logic [31:0] b);
    exp_t e;
    logic [63:0] p;
    e.tag = tag;
    if (!is_div) begin
      p = {32'h0, a} * {32'h0, b};
      e.hi = p[63:32]; e.lo = p[31:0];
    end else if (b == 32'h0) begin
      e.hi = a; e.lo = 32'hFFFF_FFFF;
    end else begin
      e.hi = a % b; e.lo = a / b;
    end
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_hi"}, hi_o, e.hi);
      check({e.tag, "_lo"}, lo_o, e.lo);
    end
  endtask

  // Counts cycles with mdu_busy_o high, starting at the current sample point.
  task automatic count_busy(output int n);
    n = 0;
    while (mdu_busy_o && n < 200) begin
      n++;
      @(negedge clk); #1;
    end
  endtask

  task automatic run_op(input string tag, input logic is_div, input logic [31:0] a,
                        input logic [31:0] b);
    int n;
    issue(1'b1, AOP_R, is_div ? FN_DIVU : FN_MULTU, a, b);
    check({tag, "_accept_stall"}, stall_o, 1'b0);
    push_exp(tag, is_div, a, b);
    issue(1'b0, AOP_R, FN_ADD, 32'h0, 32'h0);
    count_busy(n);
    check({tag, "_busy_cycles"}, n, 33);
    pop_check();
  endtask

  initial begin
    int n;
    exp_t e;
    reset = 1'b0; valid_i = 1'b0; ALUOp = 3'b0; ALUFunction = 6'b0; a_i = '0; b_i = '0;
    #12;
    check("rst_stall", stall_o, 1'b0);
    check("rst_busy", mdu_busy_o, 1'b0);
    check("rst_hilo_rd", hilo_rd_o, 1'b0);
    check("rst_hilo_data", hilo_data_o, 32'h0);
    check("rst_hi", hi_o, 32'h0);
    check("rst_lo", lo_o, 32'h0);
    for (int i = 0; i < 19; i++) begin
      ALUOp = dop[i];
      ALUFunction = (dop[i] == 3'b111) ? dfn[i] : 6'($urandom_range(0, 63));
      #1;
      check($sformatf("decode_%0d", i), ALUOperation, dexp[i]);
    end
    @(negedge clk); reset = 1'b1;

    run_op("multu_max", 1'b0, 32'hFFFF_FFFF, 32'h0000_0002);
    issue(1'b1, AOP_R, FN_MFHI, 32'h0, 32'h0);
    check("mfhi_rd", hilo_rd_o, 1'b1);
    check("mfhi_data", hilo_data_o, 32'h0000_0001);
    run_op("divu_100_7", 1'b1, 32'd100, 32'd7);
    run_op("divu_by0", 1'b1, 32'd5, 32'd0);

    // MFLO issued three cycles after a MULTU accept, with an ADD flowing in between
    issue(1'b1, AOP_R, FN_MULTU, 32'h1234_5678, 32'h9ABC_DEF1);
    push_exp("multu_mflo", 1'b0, 32'h1234_5678, 32'h9ABC_DEF1);
    e = sb[sb.size()-1];
    issue(1'b1, AOP_R, FN_ADD, 32'h1, 32'h2);
    check("add_busy_stall", stall_o, 1'b0);
    check("add_busy_op", ALUOperation, OPC_ADD);
    issue(1'b0, AOP_R, FN_ADD, 32'h0, 32'h0);
    issue(1'b1, AOP_R, FN_MFLO, 32'h0, 32'h0);
    check("mflo_stall", stall_o, 1'b1);
    check("mflo_stalled_rd", hilo_rd_o, 1'b0);
    n = 0;
    while (stall_o && n < 200) begin n++; @(negedge clk); #1; end
    check("mflo_stall_cycles", n, 31);
    check("mflo_rd", hilo_rd_o, 1'b1);
    check("mflo_data", hilo_data_o, e.lo);
    pop_check();

    // Asynchronous reset in the middle of a DIVU
    issue(1'b1, AOP_R, FN_DIVU, 32'hDEAD_BEEF, 32'h13);
    issue(1'b0, AOP_R, FN_ADD, 32'h0, 32'h0);
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("midrst_busy", mdu_busy_o, 1'b0);
    check("midrst_hi", hi_o, 32'h0);
    check("midrst_lo", lo_o, 32'h0);
    @(negedge clk); reset = 1'b1;
    #1 check("midrst_rel_busy", mdu_busy_o, 1'b0);
    run_op("multu_3x4", 1'b0, 32'd3, 32'd4);

    // Back-to-back MULTU then DIVU: the DIVU waits for IDLE
    issue(1'b1, AOP_R, FN_MULTU, 32'hCAFE_F00D, 32'h0000_0100);
    push_exp("b2b_multu", 1'b0, 32'hCAFE_F00D, 32'h0000_0100);
    issue(1'b1, AOP_R, FN_DIVU, 32'hDEAD_BEEF, 32'h0000_1234);
    check("b2b_divu_stall", stall_o, 1'b1);
    n = 0;
    while (stall_o && n < 200) begin n++; @(negedge clk); #1; end
    check("b2b_stall_cycles", n, 33);
    check("b2b_accept_busy", mdu_busy_o, 1'b0);
    pop_check();
    push_exp("b2b_divu", 1'b1, 32'hDEAD_BEEF, 32'h0000_1234);
    issue(1'b0, AOP_R, FN_ADD, 32'h0, 32'h0);
    count_busy(n);
    check("b2b_divu_busy_cycles", n, 33);
    pop_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
